// File: rtl/cmd_run_ctrl_pkg.sv
// Shared constants for the command-run controller, UART and status blocks:
// controller state encoding, ASCII command characters, default response bytes.
package cmd_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GADR,
    GEND,
    QEND,
    ERR,
    RESP
  } run_state_t;

  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_G_LO = 8'h67;
  localparam logic [7:0] CHR_G_UP = 8'h47;
  localparam logic [7:0] CHR_Q_LO = 8'h71;
  localparam logic [7:0] CHR_Q_UP = 8'h51;

  localparam logic [7:0] ACK_CHR_DEF = 8'h4B;
  localparam logic [7:0] NAK_CHR_DEF = 8'h3F;

  localparam logic [3:0] ADR_DIGITS = 4'd8;

endpackage

// File: rtl/cmd_run_ctrl_hex_ascii_dec.sv
// Combinational ASCII hex digit decoder: 0-9, a-f, A-F to a nibble.
module hex_ascii_dec (
  input  logic [7:0] chr,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (chr >= 8'h30 && chr <= 8'h39) begin
      nibble = chr[3:0];
      is_hex = 1'b1;
    end else if ((chr >= 8'h61 && chr <= 8'h66) || (chr >= 8'h41 && chr <= 8'h46)) begin
      // low nibble of 'a'/'A' is 1, so +9 maps it to 10
      nibble = chr[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/cmd_run_ctrl.sv
// Parses "g<8 hex digits>CR" (start CPU) and "qCR" (quit) from the UART byte
// stream, pulses the status block and returns a one-byte ACK/NAK response.
module cmd_run_ctrl
  import cmd_run_ctrl_pkg::*;
#(
  parameter logic [7:0] ACK_CHR = ACK_CHR_DEF,
  parameter logic [7:0] NAK_CHR = NAK_CHR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  input  logic        cpu_running,
  output logic        cpu_start,
  output logic [29:0] start_adr,
  output logic        quit_cmd,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_ack
);

  run_state_t  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic        start_q, start_d;
  logic        quit_q, quit_d;
  logic        req_q, req_d;
  logic [7:0]  data_q, data_d;

  logic [3:0]  nibble;
  logic        is_hex;
  logic        is_cr;

  hex_ascii_dec u_hex_dec (
    .chr    (rx_data),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign is_cr = (rx_data == CHR_CR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      start_q <= 1'b0;
      quit_q  <= 1'b0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      start_q <= start_d;
      quit_q  <= quit_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    start_d = 1'b0;
    quit_d  = 1'b0;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (rx_vld) begin
        if (rx_data == CHR_G_LO || rx_data == CHR_G_UP) begin
          state_d = GADR;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (rx_data == CHR_Q_LO || rx_data == CHR_Q_UP) begin
          state_d = QEND;
        end else if (!is_cr && rx_data != CHR_LF) begin
          state_d = ERR;
        end
      end
      GADR: if (rx_vld) begin
        if (is_hex) begin
          acc_d = {acc_q[27:0], nibble};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == ADR_DIGITS - 4'd1) state_d = GEND;
        end else if (is_cr) begin
          // early CR both errors and terminates, so answer NAK without waiting in ERR
          state_d = RESP;
          req_d   = 1'b1;
          data_d  = NAK_CHR;
        end else begin
          state_d = ERR;
        end
      end
      GEND: if (rx_vld) begin
        if (is_cr) begin
          state_d = RESP;
          req_d   = 1'b1;
          if (acc_q[1:0] == 2'b00 && !cpu_running) begin
            start_d = 1'b1;
            adr_d   = acc_q[31:2];
            data_d  = ACK_CHR;
          end else begin
            data_d  = NAK_CHR;
          end
        end else begin
          state_d = ERR;
        end
      end
      QEND: if (rx_vld) begin
        if (is_cr) begin
          state_d = RESP;
          quit_d  = 1'b1;
          req_d   = 1'b1;
          data_d  = ACK_CHR;
        end else begin
          state_d = ERR;
        end
      end
      ERR: if (rx_vld && is_cr) begin
        state_d = RESP;
        req_d   = 1'b1;
        data_d  = NAK_CHR;
      end
      RESP: if (tx_ack) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_start = start_q;
  assign quit_cmd  = quit_q;
  assign start_adr = adr_q;
  assign tx_req    = req_q;
  assign tx_data   = data_q;

endmodule

// File: tb/tb_cmd_run_ctrl.sv
// Directed self-checking bench for cmd_run_ctrl.
module tb_cmd_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        cpu_running;
  logic        cpu_start;
  logic [29:0] start_adr;
  logic        quit_cmd;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_start  = 0;
  int unsigned n_quit   = 0;
  int unsigned n_both   = 0;

  always #5 clk = ~clk;

  cmd_run_ctrl #(.ACK_CHR(8'h4B), .NAK_CHR(8'h3F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .cpu_running (cpu_running),
    .cpu_start   (cpu_start),
    .start_adr   (start_adr),
    .quit_cmd    (quit_cmd),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack)
  );

  always @(negedge clk) begin
    if (cpu_start) n_start++;
    if (quit_cmd) n_quit++;
    if (cpu_start && quit_cmd) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Sends body + CR, checks the registered pulses, the response byte and the handshake.
  task automatic do_cmd(input string tag, input string body, input logic [7:0] exp_chr,
                        input int unsigned exp_start, input int unsigned exp_quit,
                        input logic [29:0] exp_adr, input int unsigned delay,
                        input int inj_cycle, input logic [7:0] inj_chr, input bit inj_on_ack);
    int unsigned s0, q0, held, waited;
    s0 = n_start;
    q0 = n_quit;
    send_str(body);
    send_byte(8'h0D);
    chk({tag, ".start_lat1"}, 32'(cpu_start), 32'(exp_start));
    chk({tag, ".quit_lat1"}, 32'(quit_cmd), 32'(exp_quit));
    waited = 0;
    while (!tx_req && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, ".tx_req"}, 32'(tx_req), 32'd1);
    chk({tag, ".tx_data"}, 32'(tx_data), 32'(exp_chr));
    held = 0;
    for (int c = 0; c < int'(delay); c++) begin
      if (c == inj_cycle) begin
        rx_data = inj_chr;
        rx_vld  = 1'b1;
      end
      @(posedge clk); #1;
      rx_vld = 1'b0;
      if (tx_req) held++;
    end
    chk({tag, ".held"}, held, delay);
    tx_ack = 1'b1;
    if (inj_on_ack) begin
      rx_data = inj_chr;
      rx_vld  = 1'b1;
    end
    @(posedge clk); #1;
    tx_ack = 1'b0;
    rx_vld = 1'b0;
    chk({tag, ".req_drop"}, 32'(tx_req), 32'd0);
    chk({tag, ".n_start"}, n_start - s0, exp_start);
    chk({tag, ".n_quit"}, n_quit - q0, exp_quit);
    chk({tag, ".start_adr"}, 32'(start_adr), 32'(exp_adr));
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = '0;
    rx_vld      = 1'b0;
    cpu_running = 1'b0;
    tx_ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cpu_start", 32'(cpu_start), 32'd0);
    chk("rst.start_adr", 32'(start_adr), 32'd0);
    chk("rst.tx_req", 32'(tx_req), 32'd0);
    chk("rst.tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // accepted start: 0x1000 >> 2 = 0x400
    do_cmd("g1000", "g00001000", 8'h4B, 1, 0, 30'h400, 4, -1, 8'h00, 1'b0);
    // misaligned address -> NAK, address held
    do_cmd("G0ABC2", "G0000ABC2", 8'h3F, 0, 0, 30'h400, 2, -1, 8'h00, 1'b0);
    // short address, then a quit
    do_cmd("g123", "g123", 8'h3F, 0, 0, 30'h400, 2, -1, 8'h00, 1'b0);
    do_cmd("q_after", "q", 8'h4B, 0, 1, 30'h400, 2, -1, 8'h00, 1'b0);
    // CPU already running
    cpu_running = 1'b1;
    do_cmd("g_run", "g00000100", 8'h3F, 0, 0, 30'h400, 2, -1, 8'h00, 1'b0);
    // quit is accepted regardless of cpu_running
    do_cmd("q_run", "Q", 8'h4B, 0, 1, 30'h400, 1, -1, 8'h00, 1'b0);
    cpu_running = 1'b0;
    // delayed ack with a stray byte during RESP
    do_cmd("q_slow", "q", 8'h4B, 0, 1, 30'h400, 20, 5, 8'h78, 1'b0);
    do_cmd("q_idle", "q", 8'h4B, 0, 1, 30'h400, 1, -1, 8'h00, 1'b0);
    // CR/LF in IDLE are ignored
    do_cmd("crlf", {8'h0D, 8'h0A, 8'h0D, "q"}, 8'h4B, 0, 1, 30'h400, 1, -1, 8'h00, 1'b0);
    // unknown command, and junk after 8 digits
    do_cmd("junk", "zz", 8'h3F, 0, 0, 30'h400, 1, -1, 8'h00, 1'b0);
    do_cmd("gend_x", "g00002000x", 8'h3F, 0, 0, 30'h400, 1, -1, 8'h00, 1'b0);
    // rx byte coinciding with the ack is dropped
    do_cmd("ack_vld", "g00000010", 8'h4B, 1, 0, 30'h4, 2, -1, 8'h67, 1'b1);
    do_cmd("post_ack", "q", 8'h4B, 0, 1, 30'h4, 1, -1, 8'h00, 1'b0);

    // reset mid-command
    send_str("g0000");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.cpu_start", 32'(cpu_start), 32'd0);
    chk("mid.quit_cmd", 32'(quit_cmd), 32'd0);
    chk("mid.start_adr", 32'(start_adr), 32'd0);
    chk("mid.tx_req", 32'(tx_req), 32'd0);
    chk("mid.tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int unsigned s0, q0, reqs;
      s0 = n_start;
      q0 = n_quit;
      reqs = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (tx_req) reqs++;
      end
      chk("mid.no_pulse", (n_start - s0) + (n_quit - q0), 32'd0);
      chk("mid.no_resp", reqs, 32'd0);
    end
    do_cmd("g200", "g00000200", 8'h4B, 1, 0, 30'h80, 2, -1, 8'h00, 1'b0);

    chk("never_both", n_both, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_run_ctrl.md
CMD_RUN_CTRL -- requirements
Module: cmd_run_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rx_data, input, 8, received ASCII byte.
REQ-004 SHALL have port rx_vld, input, 1, one-cycle strobe qualifying rx_data.
REQ-005 SHALL have port cpu_running, input, 1, CPU run state from the status block.
REQ-006 SHALL have port cpu_start, output, 1, one-cycle start pulse to the status block.
REQ-007 SHALL have port start_adr, output, 30, start address [31:2].
REQ-008 SHALL have port quit_cmd, output, 1, one-cycle stop pulse to the status block.
REQ-009 SHALL have port tx_data, output, 8, response byte.
REQ-010 SHALL have port tx_req, output, 1, response request, held until acknowledged.
REQ-011 SHALL have port tx_ack, input, 1, one-cycle acknowledge from the transmitter.
REQ-012 SHALL have parameter ACK_CHR, default 8'h4B ('K'), meaning success response.
REQ-013 SHALL have parameter NAK_CHR, default 8'h3F ('?'), meaning failure response.

Function
REQ-014 SHALL implement the states IDLE, GADR, GEND, QEND, ERR and RESP.
REQ-015 SHALL transition from IDLE on 'g' or 'G' to GADR, clearing the address accumulator and digit count.
REQ-016 SHALL transition from IDLE on 'q' or 'Q' to QEND.
REQ-017 SHALL ignore CR (8'h0D) and LF (8'h0A) in IDLE.
REQ-018 SHALL transition from IDLE on any other byte to ERR.
REQ-019 SHALL, in GADR, shift each hex digit (0-9, a-f, A-F) into the 32-bit accumulator as acc = {acc[27:0], nibble} and increment the 4-bit digit count.
REQ-020 SHALL go from GADR to GEND when the digit count reaches 8.
REQ-021 SHALL go from GADR to ERR on a non-hex byte, including a CR before the 8th digit.
REQ-022 SHALL, in GEND on CR, assert cpu_start for exactly one cycle when acc[1:0]==2'b00 and cpu_running==0 (both sampled at CR), load start_adr <= acc[31:2] in the same cycle, and queue ACK_CHR.
REQ-023 SHALL, in GEND on CR when acc[1:0]!=0 or cpu_running==1, leave cpu_start low and start_adr unchanged, and queue NAK_CHR.
REQ-024 SHALL, in GEND, go to ERR on any byte other than CR.
REQ-025 SHALL, in QEND on CR, pulse quit_cmd for one cycle regardless of cpu_running and queue ACK_CHR.
REQ-026 SHALL, in QEND, go to ERR on any byte other than CR.
REQ-027 SHALL, in ERR, discard bytes until CR, then queue NAK_CHR.
REQ-028 SHALL make cpu_start/quit_cmd high in the cycle after the accepting rx_vld, i.e. registered, latency 1.
REQ-029 SHALL, on queue, enter RESP with tx_req=1 and tx_data stable.
REQ-030 SHALL drop tx_req in the cycle after tx_ack and return to IDLE.
REQ-031 SHALL drop all rx_vld bytes received in RESP.
REQ-032 SHALL hold start_adr stable except at an accepted start.
REQ-033 SHALL never assert cpu_start and quit_cmd in the same cycle.
REQ-034 SHALL treat rx_vld and tx_ack in the same cycle in RESP as: the ack completes and the byte is dropped.

Reset
REQ-035 SHALL, on rst_n low, asynchronously set the state to IDLE, the accumulator, digit count and start_adr to 0, cpu_start, quit_cmd and tx_req to 0, and tx_data to 8'h00.
REQ-036 SHALL abandon any partially received command on reset mid-operation, with no pulse or response emitted after release.

Structure
REQ-037 SHALL place the state encoding, the ASCII constants (CR, LF, 'g', 'G', 'q', 'Q') and the ACK/NAK defaults in a shared package/include used with the UART and status blocks.
REQ-038 SHALL implement the ASCII-to-nibble conversion (outputs nibble[3:0] and is_hex) as a combinational sub-module, hex_ascii_dec.

Verification
REQ-039 SHALL verify: "g00001000\r", cpu_running=0 -> one-cycle cpu_start, start_adr=30'h400, tx_data=8'h4B, then tx_req held until tx_ack.
REQ-040 SHALL verify: "G0000ABC2\r" -> no cpu_start, start_adr unchanged, NAK 8'h3F.
REQ-041 SHALL verify: "g123\r" -> ERR path, NAK, no pulse; the next "q\r" -> quit_cmd pulse, ACK.
REQ-042 SHALL verify: "g00000100\r" with cpu_running=1 -> NAK, no cpu_start.
REQ-043 SHALL verify: "q\r" with tx_ack delayed 20 cycles plus an 'x' byte during RESP -> tx_req held 20 cycles, 'x' dropped, IDLE afterwards.
REQ-044 SHALL verify: rst_n asserted after "g0000" -> all outputs 0; then "g00000200\r" -> start_adr=30'h80.
